// File: rtl/axi_lite_demux_timeout.sv
// AXI-Lite 1-to-N address demultiplexer with local DECERR for unmapped
// addresses and a per-transaction response timeout that marks hung slaves dead.

// Flat AXI-Lite request/response structs used as the default port types.
package axi_lite_demux_timeout_pkg;
   typedef struct packed {
      logic [31:0] aw_addr;
      logic [2:0]  aw_prot;
      logic        aw_valid;
      logic [31:0] w_data;
      logic [3:0]  w_strb;
      logic        w_valid;
      logic        b_ready;
      logic [31:0] ar_addr;
      logic [2:0]  ar_prot;
      logic        ar_valid;
      logic        r_ready;
   } req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      logic [1:0]  b_resp;
      logic        b_valid;
      logic        ar_ready;
      logic [31:0] r_data;
      logic [1:0]  r_resp;
      logic        r_valid;
   } resp_t;
endpackage

module axi_lite_demux_timeout #(
   parameter int unsigned               NoSlaves      = 6,
   parameter int unsigned               AxiAddrWidth  = 32,
   parameter int unsigned               AxiDataWidth  = 32,
   parameter logic [AxiAddrWidth-1:0]   BaseAddr      = 32'hfffc0000,
   parameter logic [AxiAddrWidth-1:0]   RegionSize    = 32'h100,
   parameter int unsigned               TimeoutCycles = 1024,
   parameter type                       req_t         = axi_lite_demux_timeout_pkg::req_t,
   parameter type                       resp_t        = axi_lite_demux_timeout_pkg::resp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  req_t                 slv_req_i,
   output resp_t                slv_resp_o,
   output req_t  [NoSlaves-1:0] mst_req_o,
   input  resp_t [NoSlaves-1:0] mst_resp_i,
   input  logic                 clr_i,
   output logic  [NoSlaves-1:0] dead_o,
   output logic  [15:0]         decerr_cnt_o,
   output logic  [15:0]         timeout_cnt_o
);

   localparam int unsigned IdxW     = (NoSlaves > 1) ? $clog2(NoSlaves) : 1;
   localparam int unsigned TmrW     = $clog2(TimeoutCycles);
   localparam int unsigned RegShift = $clog2(RegionSize);
   localparam int unsigned StrbW    = AxiDataWidth / 8;
   localparam logic [1:0]  RespSlvErr = 2'b10;
   localparam logic [1:0]  RespDecErr = 2'b11;

   typedef logic [IdxW-1:0]     idx_t;
   typedef logic [TmrW-1:0]     tmr_t;
   typedef logic [AxiAddrWidth:0] span_t;
   localparam span_t Span     = span_t'(NoSlaves) * span_t'(RegionSize);
   localparam tmr_t  TmrLast  = tmr_t'(TimeoutCycles - 1);

   typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_BOUT} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_OUT}  r_state_e;

   function automatic logic decode_hit(input logic [AxiAddrWidth-1:0] addr);
      logic [AxiAddrWidth-1:0] off;
      off = addr - BaseAddr;
      return (addr >= BaseAddr) && ({1'b0, off} < Span);
   endfunction

   function automatic idx_t decode_idx(input logic [AxiAddrWidth-1:0] addr);
      logic [AxiAddrWidth-1:0] off;
      off = (addr - BaseAddr) >> RegShift;
      return off[IdxW-1:0];
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, cnt} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   // write path state
   w_state_e                w_state_q;
   idx_t                    w_idx_q;
   logic [AxiAddrWidth-1:0] aw_addr_q;
   logic [2:0]              aw_prot_q;
   logic [AxiDataWidth-1:0] w_data_q;
   logic [StrbW-1:0]        w_strb_q;
   logic                    aw_vld_q, w_vld_q;
   logic [1:0]              b_resp_q;
   tmr_t                    w_tmr_q;

   // read path state
   r_state_e                r_state_q;
   idx_t                    r_idx_q;
   logic [AxiAddrWidth-1:0] ar_addr_q;
   logic [2:0]              ar_prot_q;
   logic                    ar_vld_q;
   logic [AxiDataWidth-1:0] r_data_q;
   logic [1:0]              r_resp_q;
   tmr_t                    r_tmr_q;

   // shared per-slave health and statistics
   logic [NoSlaves-1:0] dead_q, dead_d, late_w_q, late_w_d, late_r_q, late_r_d;
   logic [NoSlaves-1:0] w_to_vec, r_to_vec;
   logic [15:0]         decerr_q, decerr_d, timeout_q, timeout_d;

   resp_t w_sel, r_sel;
   assign w_sel = mst_resp_i[w_idx_q];
   assign r_sel = mst_resp_i[r_idx_q];

   logic w_accept, aw_hit, w_decerr, w_timeout;
   logic r_accept, ar_hit, r_decerr, r_timeout;
   idx_t aw_idx, ar_idx;

   assign aw_hit    = decode_hit(slv_req_i.aw_addr);
   assign aw_idx    = decode_idx(slv_req_i.aw_addr);
   assign w_accept  = (w_state_q == W_IDLE) && slv_req_i.aw_valid && slv_req_i.w_valid;
   assign w_decerr  = w_accept && !aw_hit;
   assign w_timeout = (w_state_q == W_RESP) && !w_sel.b_valid && (w_tmr_q == TmrLast);

   assign ar_hit    = decode_hit(slv_req_i.ar_addr);
   assign ar_idx    = decode_idx(slv_req_i.ar_addr);
   assign r_accept  = (r_state_q == R_IDLE) && slv_req_i.ar_valid;
   assign r_decerr  = r_accept && !ar_hit;
   assign r_timeout = (r_state_q == R_RESP) && !r_sel.r_valid && (r_tmr_q == TmrLast);

   // Write FSM: accept AW+W together, forward, time the B wait, return B upstream.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_ni) begin
         w_state_q <= W_IDLE;
         w_idx_q   <= '0;
         aw_addr_q <= '0;
         aw_prot_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         aw_vld_q  <= 1'b0;
         w_vld_q   <= 1'b0;
         b_resp_q  <= '0;
         w_tmr_q   <= '0;
      end else begin
         case (w_state_q)
            W_IDLE: if (w_accept) begin
               aw_addr_q <= slv_req_i.aw_addr;
               aw_prot_q <= slv_req_i.aw_prot;
               w_data_q  <= slv_req_i.w_data;
               w_strb_q  <= slv_req_i.w_strb;
               w_idx_q   <= aw_idx;
               if (!aw_hit) begin
                  b_resp_q  <= RespDecErr;
                  w_state_q <= W_BOUT;
               end else if (dead_q[aw_idx]) begin
                  b_resp_q  <= RespSlvErr;
                  w_state_q <= W_BOUT;
               end else begin
                  aw_vld_q  <= 1'b1;
                  w_vld_q   <= 1'b1;
                  w_state_q <= W_FWD;
               end
            end
            W_FWD: begin
               if (w_sel.aw_ready) aw_vld_q <= 1'b0;
               if (w_sel.w_ready)  w_vld_q  <= 1'b0;
               if ((!aw_vld_q || w_sel.aw_ready) && (!w_vld_q || w_sel.w_ready)) begin
                  w_tmr_q   <= '0;
                  w_state_q <= W_RESP;
               end
            end
            W_RESP: begin
               if (w_sel.b_valid) begin
                  b_resp_q  <= w_sel.b_resp;
                  w_state_q <= W_BOUT;
               end else if (w_tmr_q == TmrLast) begin
                  b_resp_q  <= RespSlvErr;
                  w_state_q <= W_BOUT;
               end else begin
                  w_tmr_q <= w_tmr_q + 1'b1;
               end
            end
            W_BOUT: if (slv_req_i.b_ready) w_state_q <= W_IDLE;
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   // Read FSM: accept AR alone, forward, time the R wait, return R upstream.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state_q <= R_IDLE;
         r_idx_q   <= '0;
         ar_addr_q <= '0;
         ar_prot_q <= '0;
         ar_vld_q  <= 1'b0;
         r_data_q  <= '0;
         r_resp_q  <= '0;
         r_tmr_q   <= '0;
      end else begin
         case (r_state_q)
            R_IDLE: if (r_accept) begin
               ar_addr_q <= slv_req_i.ar_addr;
               ar_prot_q <= slv_req_i.ar_prot;
               r_idx_q   <= ar_idx;
               if (!ar_hit) begin
                  r_resp_q  <= RespDecErr;
                  r_data_q  <= '0;
                  r_state_q <= R_OUT;
               end else if (dead_q[ar_idx]) begin
                  r_resp_q  <= RespSlvErr;
                  r_data_q  <= '0;
                  r_state_q <= R_OUT;
               end else begin
                  ar_vld_q  <= 1'b1;
                  r_state_q <= R_FWD;
               end
            end
            R_FWD: if (r_sel.ar_ready) begin
               ar_vld_q  <= 1'b0;
               r_tmr_q   <= '0;
               r_state_q <= R_RESP;
            end
            R_RESP: begin
               if (r_sel.r_valid) begin
                  r_resp_q  <= r_sel.r_resp;
                  r_data_q  <= r_sel.r_data;
                  r_state_q <= R_OUT;
               end else if (r_tmr_q == TmrLast) begin
                  r_resp_q  <= RespSlvErr;
                  r_data_q  <= '0;
                  r_state_q <= R_OUT;
               end else begin
                  r_tmr_q <= r_tmr_q + 1'b1;
               end
            end
            R_OUT: if (slv_req_i.r_ready) r_state_q <= R_IDLE;
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   // Next state of dead/late-pending flags and the saturating counters.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      w_to_vec = '0;
      r_to_vec = '0;
      if (w_timeout) w_to_vec[w_idx_q] = 1'b1;
      if (r_timeout) r_to_vec[r_idx_q] = 1'b1;
      for (int k = 0; k < NoSlaves; k++) begin
         late_w_d[k] = w_to_vec[k] | (late_w_q[k] & ~mst_resp_i[k].b_valid);
         late_r_d[k] = r_to_vec[k] | (late_r_q[k] & ~mst_resp_i[k].r_valid);
         dead_d[k]   = dead_q[k];
         if (clr_i && !late_w_q[k] && !late_r_q[k]) dead_d[k] = 1'b0;
         if (w_to_vec[k] || r_to_vec[k])            dead_d[k] = 1'b1;
      end
      decerr_d  = clr_i ? 16'd0 : sat_add(decerr_q,  {1'b0, w_decerr}  + {1'b0, r_decerr});
      timeout_d = clr_i ? 16'd0 : sat_add(timeout_q, {1'b0, w_timeout} + {1'b0, r_timeout});
   end

   // Register the shared flags and counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dead_q    <= '0;
         late_w_q  <= '0;
         late_r_q  <= '0;
         decerr_q  <= '0;
         timeout_q <= '0;
      end else begin
         dead_q    <= dead_d;
         late_w_q  <= late_w_d;
         late_r_q  <= late_r_d;
         decerr_q  <= decerr_d;
         timeout_q <= timeout_d;
      end
   end

   // Downstream ports: payload broadcast, valids/readies only on the selected or sinking port.
   always_comb begin
      for (int k = 0; k < NoSlaves; k++) begin
         mst_req_o[k]          = '0;
         mst_req_o[k].aw_addr  = aw_addr_q;
         mst_req_o[k].aw_prot  = aw_prot_q;
         mst_req_o[k].w_data   = w_data_q;
         mst_req_o[k].w_strb   = w_strb_q;
         mst_req_o[k].ar_addr  = ar_addr_q;
         mst_req_o[k].ar_prot  = ar_prot_q;
         mst_req_o[k].aw_valid = aw_vld_q && (w_idx_q == idx_t'(k));
         mst_req_o[k].w_valid  = w_vld_q  && (w_idx_q == idx_t'(k));
         mst_req_o[k].ar_valid = ar_vld_q && (r_idx_q == idx_t'(k));
         mst_req_o[k].b_ready  = ((w_state_q == W_RESP) && (w_idx_q == idx_t'(k))) || late_w_q[k];
         mst_req_o[k].r_ready  = ((r_state_q == R_RESP) && (r_idx_q == idx_t'(k))) || late_r_q[k];
      end
   end

   // Upstream port.
   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = w_accept;
      slv_resp_o.w_ready  = w_accept;
      slv_resp_o.b_valid  = (w_state_q == W_BOUT);
      slv_resp_o.b_resp   = b_resp_q;
      slv_resp_o.ar_ready = r_accept;
      slv_resp_o.r_valid  = (r_state_q == R_OUT);
      slv_resp_o.r_data   = r_data_q;
      slv_resp_o.r_resp   = r_resp_q;
   end

   assign dead_o        = dead_q;
   assign decerr_cnt_o  = decerr_q;
   assign timeout_cnt_o = timeout_q;

endmodule

// File: tb/tb_axi_lite_demux_timeout.sv
// Directed bench for axi_lite_demux_timeout (TimeoutCycles = 16).
module tb_axi_lite_demux_timeout;
   import axi_lite_demux_timeout_pkg::*;

   localparam int NS = 6;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   req_t             slv_req;
   resp_t            slv_resp;
   req_t  [NS-1:0]   mst_req;
   resp_t [NS-1:0]   mst_resp;
   logic             clr;
   logic  [NS-1:0]   dead;
   logic  [15:0]     decerr_cnt, timeout_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   axi_lite_demux_timeout #(
      .NoSlaves      (NS),
      .TimeoutCycles (16)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .slv_req_i     (slv_req),
      .slv_resp_o    (slv_resp),
      .mst_req_o     (mst_req),
      .mst_resp_i    (mst_resp),
      .clr_i         (clr),
      .dead_o        (dead),
      .decerr_cnt_o  (decerr_cnt),
      .timeout_cnt_o (timeout_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [NS-1:0] aw_valids();
      logic [NS-1:0] v;
      for (int k = 0; k < NS; k++) v[k] = mst_req[k].aw_valid;
      return v;
   endfunction

   function automatic logic [NS-1:0] w_valids();
      logic [NS-1:0] v;
      for (int k = 0; k < NS; k++) v[k] = mst_req[k].w_valid;
      return v;
   endfunction

   function automatic logic [NS-1:0] ar_valids();
      logic [NS-1:0] v;
      for (int k = 0; k < NS; k++) v[k] = mst_req[k].ar_valid;
      return v;
   endfunction

   // Read to slave 2 that never answers: SLVERR after 16 response-wait cycles.
   task automatic read_timeout_s2(input string pfx);
      slv_req.ar_addr  = 32'hfffc0200;
      slv_req.ar_valid = 1'b1;
      tick();
      slv_req.ar_valid = 1'b0;
      check({pfx, "_ar_map"}, 32'(ar_valids()), 32'h04);
      mst_resp[2].ar_ready = 1'b1;
      tick();
      mst_resp[2].ar_ready = 1'b0;
      check({pfx, "_r_ready"}, 32'(mst_req[2].r_ready), 32'd1);
      for (int i = 0; i < 15; i++) tick();
      check({pfx, "_no_r_yet"}, 32'(slv_resp.r_valid), 32'd0);
      check({pfx, "_alive_yet"}, 32'(dead), 32'h00);
      tick();
      check({pfx, "_r_valid"}, 32'(slv_resp.r_valid), 32'd1);
      check({pfx, "_r_resp"}, 32'(slv_resp.r_resp), 32'd2);
      check({pfx, "_r_data"}, slv_resp.r_data, 32'd0);
      check({pfx, "_dead"}, 32'(dead), 32'h04);
      check({pfx, "_to_cnt"}, 32'(timeout_cnt), 32'd1);
      tick();
      check({pfx, "_sink_ready"}, 32'(mst_req[2].r_ready), 32'd1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic stall_ok;
      rst_ni   = 1'b0;
      slv_req  = '0;
      mst_resp = '0;
      clr      = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      settle();

      // reset state
      check("rst_dead", 32'(dead), 32'h00);
      check("rst_decerr", 32'(decerr_cnt), 32'd0);
      check("rst_timeout", 32'(timeout_cnt), 32'd0);
      check("rst_slv_resp", 32'(slv_resp === '0), 32'd1);
      check("rst_mst_req", 32'(mst_req === '0), 32'd1);

      // 1: write to slave 1, B OKAY after 3 wait cycles
      slv_req.aw_addr  = 32'hfffc0104;
      slv_req.aw_prot  = 3'b010;
      slv_req.aw_valid = 1'b1;
      slv_req.w_data   = 32'hA5A5A5A5;
      slv_req.w_strb   = 4'hF;
      slv_req.w_valid  = 1'b1;
      slv_req.b_ready  = 1'b1;
      slv_req.r_ready  = 1'b1;
      settle();
      check("t1_aw_ready", 32'(slv_resp.aw_ready), 32'd1);
      check("t1_w_ready", 32'(slv_resp.w_ready), 32'd1);
      tick();
      slv_req.aw_valid = 1'b0;
      slv_req.w_valid  = 1'b0;
      check("t1_aw_map", 32'(aw_valids()), 32'h02);
      check("t1_w_map", 32'(w_valids()), 32'h02);
      check("t1_aw_addr", mst_req[1].aw_addr, 32'hfffc0104);
      check("t1_aw_prot", 32'(mst_req[1].aw_prot), 32'd2);
      check("t1_w_data", mst_req[1].w_data, 32'hA5A5A5A5);
      check("t1_w_strb", 32'(mst_req[1].w_strb), 32'hF);
      mst_resp[1].aw_ready = 1'b1;
      mst_resp[1].w_ready  = 1'b1;
      tick();
      mst_resp[1].aw_ready = 1'b0;
      mst_resp[1].w_ready  = 1'b0;
      check("t1_aw_done", 32'(aw_valids()), 32'h00);
      check("t1_b_ready", 32'(mst_req[1].b_ready), 32'd1);
      tick();
      tick();
      mst_resp[1].b_valid = 1'b1;
      mst_resp[1].b_resp  = 2'b00;
      settle();
      check("t1_b_early", 32'(slv_resp.b_valid), 32'd0);
      tick();
      mst_resp[1].b_valid = 1'b0;
      check("t1_b_valid", 32'(slv_resp.b_valid), 32'd1);
      check("t1_b_resp", 32'(slv_resp.b_resp), 32'd0);
      tick();
      check("t1_b_done", 32'(slv_resp.b_valid), 32'd0);

      // 2: unmapped read -> local DECERR
      slv_req.ar_addr  = 32'hfffc0800;
      slv_req.ar_valid = 1'b1;
      settle();
      check("t2_ar_ready", 32'(slv_resp.ar_ready), 32'd1);
      tick();
      slv_req.ar_valid = 1'b0;
      check("t2_r_valid", 32'(slv_resp.r_valid), 32'd1);
      check("t2_r_resp", 32'(slv_resp.r_resp), 32'd3);
      check("t2_r_data", slv_resp.r_data, 32'd0);
      check("t2_decerr", 32'(decerr_cnt), 32'd1);
      check("t2_ar_map", 32'(ar_valids()), 32'h00);
      tick();
      check("t2_r_done", 32'(slv_resp.r_valid), 32'd0);

      // 3: read timeout on slave 2, then write to dead slave 2
      read_timeout_s2("t3");
      slv_req.aw_addr  = 32'hfffc0204;
      slv_req.aw_valid = 1'b1;
      slv_req.w_valid  = 1'b1;
      tick();
      slv_req.aw_valid = 1'b0;
      slv_req.w_valid  = 1'b0;
      check("t3_dead_aw_map", 32'(aw_valids()), 32'h00);
      check("t3_dead_b_valid", 32'(slv_resp.b_valid), 32'd1);
      check("t3_dead_b_resp", 32'(slv_resp.b_resp), 32'd2);
      tick();

      // 4: late response sunk, then clear; repeat with clear before the late response
      mst_resp[2].r_valid = 1'b1;
      mst_resp[2].r_data  = 32'hDEADBEEF;
      settle();
      check("t4_sink_ready", 32'(mst_req[2].r_ready), 32'd1);
      check("t4_no_upstream", 32'(slv_resp.r_valid), 32'd0);
      tick();
      mst_resp[2].r_valid = 1'b0;
      check("t4_sink_done", 32'(mst_req[2].r_ready), 32'd0);
      check("t4_no_upstream2", 32'(slv_resp.r_valid), 32'd0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t4_clr_dead", 32'(dead), 32'h00);
      check("t4_clr_decerr", 32'(decerr_cnt), 32'd0);
      check("t4_clr_timeout", 32'(timeout_cnt), 32'd0);
      read_timeout_s2("t4b");
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t4b_dead_kept", 32'(dead), 32'h04);
      check("t4b_timeout_clr", 32'(timeout_cnt), 32'd0);
      mst_resp[2].r_valid = 1'b1;
      tick();
      mst_resp[2].r_valid = 1'b0;
      check("t4b_dead_sticky", 32'(dead), 32'h04);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t4b_dead_clr", 32'(dead), 32'h00);

      // 5: slave 0 stalls AW for 50 cycles while W completes
      slv_req.aw_addr  = 32'hfffc0000;
      slv_req.w_data   = 32'h12345678;
      slv_req.w_strb   = 4'h3;
      slv_req.aw_valid = 1'b1;
      slv_req.w_valid  = 1'b1;
      tick();
      slv_req.aw_valid = 1'b0;
      slv_req.w_valid  = 1'b0;
      mst_resp[0].w_ready = 1'b1;
      tick();
      mst_resp[0].w_ready = 1'b0;
      check("t5_w_done", 32'(w_valids()), 32'h00);
      check("t5_aw_held", 32'(aw_valids()), 32'h01);
      stall_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         stall_ok &= mst_req[0].aw_valid && (mst_req[0].aw_addr == 32'hfffc0000);
      end
      check("t5_aw_stable", 32'(stall_ok), 32'd1);
      check("t5_no_timeout", 32'(timeout_cnt), 32'd0);
      check("t5_no_b", 32'(slv_resp.b_valid), 32'd0);
      mst_resp[0].aw_ready = 1'b1;
      tick();
      mst_resp[0].aw_ready = 1'b0;
      mst_resp[0].b_valid  = 1'b1;
      tick();
      mst_resp[0].b_valid  = 1'b0;
      check("t5_b_valid", 32'(slv_resp.b_valid), 32'd1);
      check("t5_b_resp", 32'(slv_resp.b_resp), 32'd0);
      check("t5_dead", 32'(dead), 32'h00);
      tick();

      // 6: concurrent read slave 3 / write slave 4, then reset during W_RESP
      slv_req.ar_addr  = 32'hfffc0300;
      slv_req.ar_valid = 1'b1;
      slv_req.aw_addr  = 32'hfffc0400;
      slv_req.aw_valid = 1'b1;
      slv_req.w_valid  = 1'b1;
      settle();
      check("t6_both_ready", 32'({slv_resp.aw_ready, slv_resp.ar_ready}), 32'h3);
      tick();
      slv_req.ar_valid = 1'b0;
      slv_req.aw_valid = 1'b0;
      slv_req.w_valid  = 1'b0;
      check("t6_aw_map", 32'(aw_valids()), 32'h10);
      check("t6_ar_map", 32'(ar_valids()), 32'h08);
      mst_resp[4].aw_ready = 1'b1;
      mst_resp[4].w_ready  = 1'b1;
      mst_resp[3].ar_ready = 1'b1;
      tick();
      mst_resp[4].aw_ready = 1'b0;
      mst_resp[4].w_ready  = 1'b0;
      mst_resp[3].ar_ready = 1'b0;
      mst_resp[3].r_valid  = 1'b1;
      mst_resp[3].r_data   = 32'hCAFEF00D;
      mst_resp[3].r_resp   = 2'b00;
      mst_resp[4].b_valid  = 1'b1;
      mst_resp[4].b_resp   = 2'b01;
      tick();
      mst_resp[3].r_valid  = 1'b0;
      mst_resp[4].b_valid  = 1'b0;
      check("t6_r_valid", 32'(slv_resp.r_valid), 32'd1);
      check("t6_r_data", slv_resp.r_data, 32'hCAFEF00D);
      check("t6_b_valid", 32'(slv_resp.b_valid), 32'd1);
      check("t6_b_resp", 32'(slv_resp.b_resp), 32'd1);
      tick();
      slv_req.aw_addr  = 32'hfffc0500;
      slv_req.aw_valid = 1'b1;
      slv_req.w_valid  = 1'b1;
      tick();
      slv_req.aw_valid = 1'b0;
      slv_req.w_valid  = 1'b0;
      mst_resp[5].aw_ready = 1'b1;
      mst_resp[5].w_ready  = 1'b1;
      tick();
      mst_resp[5].aw_ready = 1'b0;
      mst_resp[5].w_ready  = 1'b0;
      check("t6_in_resp", 32'(mst_req[5].b_ready), 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("t6_rst_mst", 32'(mst_req === '0), 32'd1);
      check("t6_rst_slv", 32'(slv_resp === '0), 32'd1);
      check("t6_rst_dead", 32'(dead), 32'h00);
      tick();
      rst_ni = 1'b1;
      tick();
      check("t6_post_rst_mst", 32'(mst_req === '0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
